controle_seq: RTL and testbench
===============================

# controle_seq

Parametrised instruction sequencer for the calculator datapath. It replaces the fixed free-running control FSM with a start/done-handshaked sequencer that takes a 4-bit instruction and shift amount, waits for operator `enter` strokes to load X and Y, and drives the X/Y/Z register commands and ULA select for all seven ULA operations, multi-cycle shifts and a clear. It sits between the operator inputs (switches/keys) and the register/ULA datapath.

## Interface
- `TW`, 4: width of `Tx`/`Ty`/`Tz`/`Tula`; codes occupy bits [2:0], upper bits always 0; legal range ≥ 3.
- `SHW`, 3: width of `amount` and of the shift counter.
- `clock  in  1`: rising-edge clock.
- `reset_n  in  1`: reset, asynchronous, active-low.
- `start  in  1`: begin instruction; sampled only in IDLE.
- `instr  in  4`: instruction, latched on accepted `start`.
- `amount  in  SHW`: shift count, latched on accepted `start`.
- `enter  in  1`: operator strobe; internally rising-edge detected.
- `S  out  4`: current state.
- `Tx`, `Ty`, `Tz`  out  TW: register commands: HOLD=0, LOAD=1, SHIFTR=2, SHIFTL=3, RESET=4.
- `Tula  out  TW`: ULA select: ADD=0, SUB=1, MAIOR=2, MENOR=3, IGUAL=4, XOR=5, AND=6.
- `busy  out  1`: high whenever S≠IDLE.
- `done  out  1`: one-cycle pulse, in DONE.
- `err  out  1`: high with `done` when the instruction was illegal.

## Operation
- Instruction map: 0–6 ULA op (Z = X op Y); 7 SHR (Z = Y>>amount); 8 SHL (Z = Y<<amount); 15 CLEAR; 9–14 illegal.
- State codes: IDLE 0, WAIT_X 1, LOAD_X 2, WAIT_Y 3, LOAD_Y 4, SHIFT 5, EXEC 6, CLEAR 7, DONE 8; 9–15 unreachable, recover to IDLE.
- Enter edge `ent` = `enter` & ~`enter_q`; `enter_q` registered every cycle, reset 0.
- Transitions:
  - IDLE: `start`=0 → stay; instr 0–6 → WAIT_X; 7/8 → WAIT_Y; 15 → CLEAR; 9–14 → DONE.
  - WAIT_X: `ent` → LOAD_X. LOAD_X → WAIT_Y. WAIT_Y: `ent` → LOAD_Y.
  - LOAD_Y: shift instr with amount≠0 → SHIFT (counter loaded with amount); otherwise → EXEC.
  - SHIFT: counter decrements each cycle; leaves to EXEC in the cycle the counter is 1, so SHIFT lasts exactly `amount` cycles.
  - EXEC → DONE; CLEAR → DONE; DONE → IDLE.
- Outputs per state (unlisted fields HOLD, `Tula`=ADD):
  - IDLE, WAIT_X, WAIT_Y, DONE: all HOLD.
  - LOAD_X: Tx=LOAD, Ty=RESET, Tz=RESET.
  - LOAD_Y: Ty=LOAD; Tx=RESET for shift instructions, else HOLD.
  - SHIFT: Ty=SHIFTR (instr 7) or SHIFTL (instr 8).
  - EXEC: Tz=LOAD; `Tula`=instr[2:0] for 0–6, ADD for shifts (X=0, so Z=Y).
  - CLEAR: Tx=Ty=Tz=RESET.
- `start` while busy is ignored; `instr`/`amount` changes after acceptance have no effect.
- `ent` outside WAIT_X/WAIT_Y is ignored; holding `enter` high yields one load only.

## Timing
- All outputs registered, updated on the same edge as S; they always match the current S.
- Reset (any time, including mid-instruction): S=IDLE, Tx/Ty/Tz=HOLD, `Tula`=ADD, busy/done/err=0, counter 0, latches 0, `enter_q`=0. Takes effect immediately and asynchronously; the first transition occurs on the first edge after release.
- `start` sampled at edge k → S≠IDLE from k; `busy` rises at k.
- ULA op, with `ent` at edges a and b: LOAD_X at a, LOAD_Y at b, EXEC at b+1, DONE at b+2, IDLE at b+3.
- Shift by n≥1: SHIFT at b+1..b+n, EXEC at b+n+1, DONE at b+n+2.
- CLEAR: CLEAR at k, DONE at k+1. Illegal: DONE (err=1) at k.
- A new `start` is accepted at the earliest on the edge on which S is IDLE.

## Test plan
- SUB (instr 1): start, then `enter` pulses in WAIT_X and WAIT_Y → S 0,1,2,3,4,6,8,0. LOAD_X: Tx=1, Ty=4, Tz=4. LOAD_Y: Ty=1. EXEC: Tz=1, Tula=1. `done`=1 for one cycle, err=0.
- SHR (instr 7), amount=3 → LOAD_Y with Tx=4 and Ty=1, then exactly 3 cycles of S=5 with Ty=2, then EXEC with Tz=1, Tula=0, then DONE.
- SHL (instr 8), amount=0 → LOAD_Y goes directly to EXEC with no SHIFT cycle; amount=7 → 7 cycles of Ty=3.
- Illegal instr 10 → S=8 at the next edge, `done`=`err`=1 for one cycle, all T fields HOLD throughout. CLEAR (instr 15) → one cycle with Tx=Ty=Tz=4, then `done`.
- `enter` held high through WAIT_X and WAIT_Y → only LOAD_X occurs, and the FSM stays in WAIT_Y until `enter` falls and rises again. `start` pulsed while busy → ignored.
- `reset_n` low during SHIFT (mid-count) → S=0, all outputs at reset values immediately without waiting for a clock edge. After release, a new `start` runs a full sequence normally.

Source files
------------

// File: rtl/controle_seq.sv
`default_nettype none
// ============================================================================
//  Module   : controle_seq
//  Purpose  : start/done handshaked instruction sequencer for the calculator
//             datapath (X/Y/Z register commands, ULA select, multi-cycle shift)
//  Revision : 1.0  initial release
// ============================================================================

module controle_seq #(
  parameter int TW  = 4,
  parameter int SHW = 3
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [3:0]     instr,
  input  logic [SHW-1:0] amount,
  input  logic           enter,
  output logic [3:0]     S,
  output logic [TW-1:0]  Tx,
  output logic [TW-1:0]  Ty,
  output logic [TW-1:0]  Tz,
  output logic [TW-1:0]  Tula,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_WAIT_X = 4'd1,
    ST_LOAD_X = 4'd2,
    ST_WAIT_Y = 4'd3,
    ST_LOAD_Y = 4'd4,
    ST_SHIFT  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_CLEAR  = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

  localparam logic [TW-1:0] c_hold   = TW'(0);
  localparam logic [TW-1:0] c_load   = TW'(1);
  localparam logic [TW-1:0] c_shiftr = TW'(2);
  localparam logic [TW-1:0] c_shiftl = TW'(3);
  localparam logic [TW-1:0] c_reset  = TW'(4);
  localparam logic [TW-1:0] c_add    = TW'(0);

  state_t          r_state;
  logic [3:0]      r_instr;
  logic [SHW-1:0]  r_amount;
  logic [SHW-1:0]  r_cnt;
  logic            r_enter_q;

  state_t          w_next;
  logic [3:0]      w_ins;
  logic            w_ent;
  logic            w_shift_ins;
  logic            w_illegal;
  logic [TW-1:0]   w_tx;
  logic [TW-1:0]   w_ty;
  logic [TW-1:0]   w_tz;
  logic [TW-1:0]   w_tula;

  assign w_ent = enter & ~r_enter_q;

  // w_ins is the instruction that governs the state being entered: the live
  // input on an accepted start, the latched copy everywhere else.
  always_comb begin
    w_next = r_state;
    w_ins  = r_instr;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_ins = instr;
          if (instr <= 4'd6)
            w_next = ST_WAIT_X;
          else if (instr == 4'd7 || instr == 4'd8)
            w_next = ST_WAIT_Y;
          else if (instr == 4'd15)
            w_next = ST_CLEAR;
          else
            w_next = ST_DONE;
        end
      end
      ST_WAIT_X: if (w_ent) w_next = ST_LOAD_X;
      ST_LOAD_X: w_next = ST_WAIT_Y;
      ST_WAIT_Y: if (w_ent) w_next = ST_LOAD_Y;
      ST_LOAD_Y: begin
        if ((r_instr == 4'd7 || r_instr == 4'd8) && r_amount != '0)
          w_next = ST_SHIFT;
        else
          w_next = ST_EXEC;
      end
      ST_SHIFT:  if (r_cnt == SHW'(1)) w_next = ST_EXEC;
      ST_EXEC:   w_next = ST_DONE;
      ST_CLEAR:  w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign w_shift_ins = (w_ins == 4'd7) || (w_ins == 4'd8);
  assign w_illegal   = (w_ins >= 4'd9) && (w_ins <= 4'd14);

  // Output decode for the next state so the registered outputs track S.
  always_comb begin
    w_tx   = c_hold;
    w_ty   = c_hold;
    w_tz   = c_hold;
    w_tula = c_add;
    case (w_next)
      ST_LOAD_X: begin
        w_tx = c_load;
        w_ty = c_reset;
        w_tz = c_reset;
      end
      ST_LOAD_Y: begin
        w_ty = c_load;
        if (w_shift_ins) w_tx = c_reset;
      end
      ST_SHIFT:  w_ty = (w_ins == 4'd7) ? c_shiftr : c_shiftl;
      ST_EXEC: begin
        w_tz = c_load;
        // X was cleared for shifts, so ADD passes Y through to Z.
        w_tula = w_shift_ins ? c_add : TW'(w_ins[2:0]);
      end
      ST_CLEAR: begin
        w_tx = c_reset;
        w_ty = c_reset;
        w_tz = c_reset;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_instr   <= '0;
      r_amount  <= '0;
      r_cnt     <= '0;
      r_enter_q <= 1'b0;
      Tx        <= c_hold;
      Ty        <= c_hold;
      Tz        <= c_hold;
      Tula      <= c_add;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_enter_q <= enter;
      r_state   <= w_next;
      Tx        <= w_tx;
      Ty        <= w_ty;
      Tz        <= w_tz;
      Tula      <= w_tula;
      busy      <= (w_next != ST_IDLE);
      done      <= (w_next == ST_DONE);
      err       <= (w_next == ST_DONE) && w_illegal;
      if (r_state == ST_IDLE && start) begin
        r_instr  <= instr;
        r_amount <= amount;
      end
      if (r_state == ST_LOAD_Y && w_next == ST_SHIFT)
        r_cnt <= r_amount;
      else if (r_state == ST_SHIFT)
        r_cnt <= r_cnt - SHW'(1);
    end
  end

  assign S = r_state;

endmodule

`default_nettype wire

// File: tb/tb_controle_seq.sv
`default_nettype none
// Randomized bench for controle_seq: each instruction is turned into an
// expected per-edge state trace built from the sequencing rules.

module tb_controle_seq;

  localparam int TW  = 4;
  localparam int SHW = 3;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           start;
  logic [3:0]     instr;
  logic [SHW-1:0] amount;
  logic           enter;
  logic [3:0]     S;
  logic [TW-1:0]  Tx, Ty, Tz, Tula;
  logic           busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;
  int txn   = 0;
  string fname [7] = '{"Tx", "Ty", "Tz", "Tula", "busy", "done", "err"};

  always #5 clock = ~clock;

  controle_seq #(.TW(TW), .SHW(SHW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .instr  (instr),
    .amount (amount),
    .enter  (enter),
    .S      (S),
    .Tx     (Tx),
    .Ty     (Ty),
    .Tz     (Tz),
    .Tula   (Tula),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected output field for a given state and instruction.
  function automatic int ref_field(input int st, input int ins, input int f);
    bit sh = (ins == 7) || (ins == 8);
    int tx = 0, ty = 0, tz = 0, tula = 0;
    case (st)
      2: begin tx = 1; ty = 4; tz = 4; end
      4: begin ty = 1; tx = sh ? 4 : 0; end
      5: ty = (ins == 7) ? 2 : 3;
      6: begin tz = 1; tula = sh ? 0 : ins; end
      7: begin tx = 4; ty = 4; tz = 4; end
      default: ;
    endcase
    case (f)
      0: return tx;
      1: return ty;
      2: return tz;
      3: return tula;
      4: return (st != 0) ? 1 : 0;
      5: return (st == 8) ? 1 : 0;
      default: return (st == 8 && ins >= 9 && ins <= 14) ? 1 : 0;
    endcase
  endfunction

  function automatic int dut_field(input int f);
    case (f)
      0: return int'(Tx);
      1: return int'(Ty);
      2: return int'(Tz);
      3: return int'(Tula);
      4: return int'(busy);
      5: return int'(done);
      default: return int'(err);
    endcase
  endfunction

  task automatic check_cycle(input string ctx, input int st, input int ins);
    check_eq({ctx, " S"}, int'(S), st);
    for (int f = 0; f < 7; f++)
      check_eq($sformatf("%s %s", ctx, fname[f]), dut_field(f), ref_field(st, ins, f));
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    start  = 1'b0;
    enter  = 1'b0;
    instr  = 4'($urandom_range(0, 15));
    amount = 3'($urandom_range(0, 7));
    @(posedge clock);
    #1;
    check_cycle("idle", 0, 0);
  endtask

  // gx/gy: WAIT_X/WAIT_Y edges before the enter rise; h: extra edges enter
  // stays high after the first rise (h <= gy-1).
  task automatic run_op(input int ins, input int amt, input int gx, input int gy, input int h);
    int exp_s[$];
    bit env[$];
    txn++;
    if (ins <= 6) begin
      for (int i = 0; i < gx; i++) begin exp_s.push_back(1); env.push_back(1'b0); end
      exp_s.push_back(2); env.push_back(1'b1);
      for (int i = 0; i < gy; i++) begin exp_s.push_back(3); env.push_back(i < h); end
      exp_s.push_back(4); env.push_back(1'b1);
      exp_s.push_back(6);
    end else if (ins == 7 || ins == 8) begin
      for (int i = 0; i < gy; i++) begin exp_s.push_back(3); env.push_back(1'b0); end
      exp_s.push_back(4); env.push_back(1'b1);
      for (int i = 0; i < amt; i++) exp_s.push_back(5);
      exp_s.push_back(6);
    end else if (ins == 15) begin
      exp_s.push_back(7);
    end
    exp_s.push_back(8);
    exp_s.push_back(0);
    for (int j = 0; j < exp_s.size(); j++) begin
      @(negedge clock);
      // after acceptance, start/instr/amount are noise that must be ignored
      start  = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      instr  = (j == 0) ? 4'(ins) : 4'($urandom_range(0, 15));
      amount = (j == 0) ? 3'(amt) : 3'($urandom_range(0, 7));
      enter  = (j < env.size()) ? env[j] : 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      check_cycle($sformatf("t%0d i%0d e%0d", txn, ins, j), exp_s[j], ins);
    end
    idle_cycle();
  endtask

  task automatic reset_mid_shift();
    @(negedge clock); start = 1'b1; instr = 4'd7; amount = 3'd6; enter = 1'b0;
    @(negedge clock); start = 1'b0; enter = 1'b1;
    @(negedge clock); enter = 1'b0;
    @(posedge clock); @(posedge clock);
    #1;
    check_cycle("pre-rst", 5, 7);
    #2;
    reset_n = 1'b0;
    #1;
    check_cycle("async-rst", 0, 0);
    repeat (2) @(negedge clock);
    check_cycle("held-rst", 0, 0);
    reset_n = 1'b1;
    idle_cycle();
  endtask

  initial begin
    int ins, gy;
    reset_n = 1'b1;
    start   = 1'b0;
    enter   = 1'b0;
    instr   = 4'd0;
    amount  = 3'd0;
    #2 reset_n = 1'b0;
    #1;
    check_cycle("reset", 0, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle_cycle();

    run_op(1, 0, 2, 2, 0);
    run_op(7, 3, 0, 2, 0);
    run_op(8, 0, 0, 1, 0);
    run_op(8, 7, 0, 2, 0);
    run_op(10, 0, 0, 0, 0);
    run_op(15, 0, 0, 0, 0);
    run_op(2, 0, 1, 4, 3);
    run_op(6, 0, 3, 1, 0);

    for (int n = 0; n < 60; n++) begin
      ins = $urandom_range(0, 15);
      gy  = $urandom_range(1, 4);
      run_op(ins, $urandom_range(0, 7), $urandom_range(1, 3), gy, $urandom_range(0, gy - 1));
    end

    reset_mid_shift();
    run_op(0, 0, 1, 1, 0);
    run_op(7, 1, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
